// File: rtl/ped_phase_pkg.sv
// Shared phase codes and the phase-to-lamp decode for the intersection sequencer.
package ped_phase_pkg;

  typedef enum logic [2:0] {
    N_GREEN  = 3'd0,
    N_YELLOW = 3'd1,
    ALLRED_1 = 3'd2,
    E_GREEN  = 3'd3,
    E_YELLOW = 3'd4,
    ALLRED_2 = 3'd5,
    PED_WALK = 3'd6
  } phase_e;

  typedef struct packed {
    logic nr;
    logic ng;
    logic ny;
    logic er;
    logic eg;
    logic ey;
    logic walk;
  } lamps_t;

  // Any code without a lamp pattern of its own shows all-red.
  function automatic lamps_t phase_lamps(input logic [2:0] ph);
    lamps_t l;
    l = '{nr: 1'b1, ng: 1'b0, ny: 1'b0, er: 1'b1, eg: 1'b0, ey: 1'b0, walk: 1'b0};
    case (ph)
      N_GREEN:  begin l.nr = 1'b0; l.ng = 1'b1; end
      N_YELLOW: begin l.nr = 1'b0; l.ny = 1'b1; end
      E_GREEN:  begin l.er = 1'b0; l.eg = 1'b1; end
      E_YELLOW: begin l.er = 1'b0; l.ey = 1'b1; end
      PED_WALK: l.walk = 1'b1;
      default:  ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ped_phase_sequencer_timer.sv
// Dwell counter: clears on phase entry, counts EN ticks, saturates at all-ones.
module phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] done_at,
  input  logic [CW-1:0] ge_at,
  output logic          done,
  output logic          ge
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Both flags only mean something on a tick cycle.
  assign done = inc && (cnt_q == done_at);
  assign ge   = inc && (cnt_q >= ge_at);

endmodule

// File: rtl/ped_phase_sequencer.sv
// North/East lamp phase controller with pedestrian WALK service and internal dwell timing.
module ped_phase_sequencer
  import ped_phase_pkg::*;
#(
  parameter int T_GREEN_MIN = 8,
  parameter int T_GREEN_MAX = 24,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 6,
  parameter int CW          = 5
) (
  input  logic       clk,
  input  logic       R,
  input  logic       EN,
  input  logic       C,
  input  logic       PB,
  output logic       NR,
  output logic       NG,
  output logic       NY,
  output logic       ER,
  output logic       EG,
  output logic       EY,
  output logic       WALK,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [CW-1:0] TY_LAST   = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] TAR_LAST  = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] TW_LAST   = CW'(T_WALK - 1);
  localparam logic [CW-1:0] TMAX_LAST = CW'(T_GREEN_MAX - 1);
  localparam logic [CW-1:0] TMIN_LAST = CW'(T_GREEN_MIN - 1);

  phase_e        phase_q, phase_d;
  logic          ped_q, ped_d;
  logic [CW-1:0] done_at;
  logic          done, ge;
  lamps_t        lamps;

  always_comb begin
    done_at = '0;
    case (phase_q)
      N_YELLOW, E_YELLOW: done_at = TY_LAST;
      ALLRED_1, ALLRED_2: done_at = TAR_LAST;
      PED_WALK:           done_at = TW_LAST;
      E_GREEN:            done_at = TMAX_LAST;
      default:            done_at = '0;
    endcase
  end

  phase_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .rst     (R),
    .clr     (phase_d != phase_q),
    .inc     (EN),
    .done_at (done_at),
    .ge_at   (TMIN_LAST),
    .done    (done),
    .ge      (ge)
  );

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      N_GREEN:  if (ge && (C || ped_q)) phase_d = N_YELLOW;
      N_YELLOW: if (done) phase_d = ALLRED_1;
      // Pedestrian is served ahead of East traffic.
      ALLRED_1: if (done) phase_d = ped_q ? PED_WALK : E_GREEN;
      E_GREEN:  if (done || (ge && (!C || ped_q))) phase_d = E_YELLOW;
      E_YELLOW: if (done) phase_d = ALLRED_2;
      ALLRED_2: if (done) phase_d = N_GREEN;
      PED_WALK: if (done) phase_d = ALLRED_2;
      default:  phase_d = ALLRED_2;
    endcase
  end

  always_comb begin
    ped_d = ped_q;
    if (PB && phase_q != PED_WALK)          ped_d = 1'b1;
    if (phase_d == PED_WALK && phase_q != PED_WALK) ped_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      phase_q <= ALLRED_2;
      ped_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ped_q   <= ped_d;
    end
  end

  assign lamps       = phase_lamps(phase_q);
  assign NR          = lamps.nr;
  assign NG          = lamps.ng;
  assign NY          = lamps.ny;
  assign ER          = lamps.er;
  assign EG          = lamps.eg;
  assign EY          = lamps.ey;
  assign WALK        = lamps.walk;
  assign ped_pending = ped_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_ped_phase_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a tick-count reference model.
module tb_ped_phase_sequencer;

  localparam int TMIN = 8, TMAX = 24, TY = 3, TAR = 1, TW = 6, SAT = 31;

  logic       clk = 1'b0;
  logic       R = 1'b1, EN = 1'b0, C = 1'b0, PB = 1'b0;
  logic       NR, NG, NY, ER, EG, EY, WALK, ped_pending;
  logic [2:0] phase;

  int vecs = 0, errs = 0;

  // model state: phase, EN ticks already spent in it, pending request
  int m_ph = 5, m_tk = 0;
  bit m_ped = 1'b0;
  bit en_alt = 1'b0;

  // {NR,NG,NY,ER,EG,EY,WALK} for phases 0..6
  logic [6:0] lamp_tbl [0:6] = '{7'b0101000, 7'b0011000, 7'b1001000, 7'b1000100,
                                 7'b1000010, 7'b1001000, 7'b1001001};

  ped_phase_sequencer dut (
    .clk(clk), .R(R), .EN(EN), .C(C), .PB(PB),
    .NR(NR), .NG(NG), .NY(NY), .ER(ER), .EG(EG), .EY(EY), .WALK(WALK),
    .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // n = ordinal of the current tick within the phase; a phase of dwell T ends on its T-th tick
  task automatic model_step(input bit r, input bit en, input bit c, input bit pb);
    int nxt, n;
    if (r) begin
      m_ph = 5; m_tk = 0; m_ped = 1'b0;
    end else begin
      nxt = m_ph;
      n   = m_tk + 1;
      if (en) begin
        case (m_ph)
          0: if (n >= TMIN && (c || m_ped)) nxt = 1;
          1: if (n == TY) nxt = 2;
          2: if (n == TAR) nxt = m_ped ? 6 : 3;
          3: if (n == TMAX || (n >= TMIN && (!c || m_ped))) nxt = 4;
          4: if (n == TY) nxt = 5;
          5: if (n == TAR) nxt = 0;
          6: if (n == TW) nxt = 5;
          default: nxt = 5;
        endcase
      end
      if (nxt == 6 && m_ph != 6)  m_ped = 1'b0;
      else if (pb && m_ph != 6)   m_ped = 1'b1;
      if (nxt != m_ph)            m_tk = 0;
      else if (en && m_tk < SAT)  m_tk = m_tk + 1;
      m_ph = nxt;
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit c, input bit pb);
    R = r; EN = en; C = c; PB = pb;
    @(posedge clk);
    model_step(r, en, c, pb);
    #1;
    chk("phase", {29'd0, phase}, m_ph);
    chk("lamps", {25'd0, NR, NG, NY, ER, EG, EY, WALK}, {25'd0, lamp_tbl[m_ph]});
    chk("ped_pending", {31'd0, ped_pending}, {31'd0, m_ped});
  endtask

  // cycles spent in the current phase from just after its entry edge
  task automatic run_dwell(input bit c, input bit tog, output int n);
    logic [2:0] start;
    start = phase;
    n = 0;
    while (phase == start && n < 200) begin
      if (tog) begin
        cyc(1'b0, en_alt, c, 1'b0);
        en_alt = ~en_alt;
      end else begin
        cyc(1'b0, 1'b1, c, 1'b0);
      end
      n++;
    end
  endtask

  int car_ph  [6] = '{0, 1, 2, 3, 4, 5};
  int car_len [6] = '{8, 3, 1, 24, 3, 1};
  int ped_ph  [5] = '{0, 1, 2, 6, 5};
  int ped_len [5] = '{5, 3, 1, 6, 1};

  initial begin
    int n;
    bit rc;

    // reset and start-up
    cyc(1, 1, 0, 0);
    chk("rst_phase", {29'd0, phase}, 32'd5);
    chk("rst_lamps", {25'd0, NR, NG, NY, ER, EG, EY, WALK}, 32'b1001000);
    cyc(0, 1, 0, 0);
    chk("start_phase", {29'd0, phase}, 32'd0);
    chk("start_lamps", {25'd0, NR, NG, NY, ER, EG, EY, WALK}, 32'b0101000);

    // no demand: rests in N_GREEN
    repeat (100) cyc(0, 1, 0, 0);
    chk("idle_phase", {29'd0, phase}, 32'd0);
    chk("idle_walk", {31'd0, WALK}, 32'd0);

    // car cycle from a fresh N_GREEN entry, C held
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      chk("car_ph", {29'd0, phase}, car_ph[i]);
      run_dwell(1'b1, 1'b0, n);
      chk("car_dwell", n, car_len[i]);
    end
    chk("car_back", {29'd0, phase}, 32'd0);

    // pedestrian pulse at N_GREEN timer=2
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("ped_latch", {31'd0, ped_pending}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("ped_ph", {29'd0, phase}, ped_ph[i]);
      if (ped_ph[i] == 6) begin
        chk("ped_walk", {31'd0, WALK}, 32'd1);
        chk("ped_clr", {31'd0, ped_pending}, 32'd0);
      end
      run_dwell(1'b0, 1'b0, n);
      chk("ped_dwell", n, ped_len[i]);
    end
    chk("ped_back", {29'd0, phase}, 32'd0);

    // EN gating: alternate EN, every dwell doubles
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    en_alt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_dwell(1'b1, 1'b1, n);
      chk("gate_dwell", n, 2 * car_len[i]);
    end
    cyc(0, 0, 1, 1);
    chk("gate_pb", {31'd0, ped_pending}, 32'd1);
    en_alt = 1'b1;

    // mid-operation reset in E_GREEN with a pending request
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) run_dwell(1'b1, 1'b0, n);
    chk("mid_in_eg", {29'd0, phase}, 32'd3);
    repeat (4) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    chk("mid_ped", {31'd0, ped_pending}, 32'd1);
    cyc(1, 1, 1, 0);
    chk("mid_phase", {29'd0, phase}, 32'd5);
    chk("mid_ped_clr", {31'd0, ped_pending}, 32'd0);
    cyc(0, 1, 1, 0);
    chk("mid_restart", {29'd0, phase}, 32'd0);

    // random traffic
    rc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rc = ~rc;
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, rc,
          $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
